// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32 load/store unit, IDLE/BUSY/DONE handshake to a word-addressed data memory.
// Optional feature macro MISALIGN_TRAP_EN: misaligned accesses complete at once with o_misaligned=1 instead of being forced aligned.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [4:0]  o_rd,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  state_t      state;
  state_t      state_next;
  size_t       req_size;
  size_t       size_q;
  logic [1:0]  req_offset;
  logic [1:0]  offset_q;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        req_trap;
  logic        accept;
  logic        we_q;
  logic        unsigned_q;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign o_ready    = (state == IDLE);
  assign o_done     = (state == DONE);
  assign accept     = i_valid & o_ready;
  assign o_dmem_ren = (state == BUSY) & ~we_q;
  assign o_dmem_wen = (state == BUSY) & we_q;

  // Request decode: size, effective lane offset (offending bits cleared), byte enables, replicated store data.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    req_size   = SZ_WORD;
    req_offset = 2'b00;
    req_mask   = 4'b1111;
    req_wdata  = i_wdata;
    case (i_funct3[1:0])
      2'b00:   req_size = SZ_BYTE;
      2'b01:   req_size = SZ_HALF;
      default: req_size = SZ_WORD;
    endcase
    case (req_size)
      SZ_BYTE: begin
        req_offset = i_addr[1:0];
        req_mask   = 4'b0001 << i_addr[1:0];
        req_wdata  = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_offset = {i_addr[1], 1'b0};
        req_mask   = i_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata  = {2{i_wdata[15:0]}};
      end
      default: begin
        req_offset = 2'b00;
        req_mask   = 4'b1111;
        req_wdata  = i_wdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q;

  assign req_trap = ((req_size == SZ_HALF) & i_addr[0]) |
                    ((req_size == SZ_WORD) & (i_addr[1:0] != 2'b00));
  assign o_misaligned = misaligned_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      misaligned_q <= 1'b0;
    end else if (accept) begin
      misaligned_q <= req_trap;
    end
  end
`else
  assign req_trap     = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_trap ? DONE : BUSY;
      BUSY:    if (i_dmem_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    load_byte = i_dmem_rdata[{offset_q, 3'b000} +: 8];
    load_half = offset_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{~unsigned_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_data = {{16{~unsigned_q & load_half[15]}}, load_half};
      default: load_data = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dmem_addr  <= 32'h0;
      o_dmem_wdata <= 32'h0;
      o_dmem_mask  <= 4'h0;
      o_rdata      <= 32'h0;
      o_rd         <= 5'h0;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      offset_q     <= 2'b00;
      unsigned_q   <= 1'b0;
    end else begin
      if (accept) begin
        o_dmem_addr  <= {i_addr[31:2], 2'b00};
        o_dmem_wdata <= req_wdata;
        o_dmem_mask  <= req_mask;
        o_rdata      <= 32'h0;
        o_rd         <= i_rd;
        we_q         <= i_we;
        size_q       <= req_size;
        offset_q     <= req_offset;
        unsigned_q   <= i_funct3[2];
      end
      if ((state == BUSY) && i_dmem_ack) begin
        o_rdata <= we_q ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expectations queued at issue, compared when o_done pulses.
// Expectations track the MISALIGN_TRAP_EN build macro.
module tb_load_store_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_ren;
  logic        o_dmem_wen;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic [4:0]  o_rd;
  logic        o_misaligned;

  load_store_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_we         (i_we),
    .i_funct3     (i_funct3),
    .i_rd         (i_rd),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_ren   (o_dmem_ren),
    .o_dmem_wen   (o_dmem_wen),
    .o_dmem_wdata (o_dmem_wdata),
    .o_dmem_mask  (o_dmem_mask),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_rd         (o_rd),
    .o_misaligned (o_misaligned)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        we;
    logic        trap;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mis;
    int          n_strobe;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model written in byte-lane arithmetic.
  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                                 input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] resp);
    exp_t        e;
    int          size;
    int          off;
    logic [31:0] keep;
    logic [31:0] val;
    bit          mis;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = (int'(addr[1:0]) % size) != 0;
    off  = int'(addr[1:0]) - (int'(addr[1:0]) % size);
`ifdef MISALIGN_TRAP_EN
    e.trap = mis;
`else
    e.trap = 1'b0;
`endif
    e.addr = addr & 32'hFFFF_FFFC;
    e.mask = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    keep = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    val  = (resp >> (8 * off)) & keep;
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~keep;
    e.rdata    = (we || e.trap) ? 32'h0 : val;
    e.we       = we;
    e.rd       = rd;
    e.mis      = e.trap;
    e.n_strobe = 0;
    e.acc_cyc  = 0;
    e.lat      = 0;
    return e;
  endfunction

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Monitor: bus behaviour while strobing, scoreboard pop on o_done.
  initial begin
    int          ren_cnt;
    int          wen_cnt;
    bit          seen;
    bit          ready_due;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_mask;
    exp_t        e;
    ren_cnt = 0; wen_cnt = 0; seen = 0; ready_due = 0;
    bus_addr = 0; bus_wdata = 0; bus_mask = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        ren_cnt = 0; wen_cnt = 0; seen = 0; ready_due = 0;
      end else begin
        if (ready_due) begin
          check("ready_after_done", 32'(o_ready), 32'd1);
          ready_due = 0;
        end
        if (o_dmem_ren || o_dmem_wen) begin
          check("ready_low_busy", 32'(o_ready), 32'd0);
          if (seen) begin
            check("hold_addr", o_dmem_addr, bus_addr);
            check("hold_mask", 32'(o_dmem_mask), 32'(bus_mask));
            check("hold_wdata", o_dmem_wdata, bus_wdata);
          end
          bus_addr = o_dmem_addr; bus_mask = o_dmem_mask; bus_wdata = o_dmem_wdata;
          seen = 1;
          ren_cnt += int'(o_dmem_ren);
          wen_cnt += int'(o_dmem_wen);
        end
        if (o_done) begin
          check("ready_low_done", 32'(o_ready), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(o_done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rdata", o_rdata, e.rdata);
            check("rd", 32'(o_rd), 32'(e.rd));
            check("misaligned", 32'(o_misaligned), 32'(e.mis));
            check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            check("ren_cycles", 32'(ren_cnt), e.we ? 32'd0 : 32'(e.n_strobe));
            check("wen_cycles", 32'(wen_cnt), e.we ? 32'(e.n_strobe) : 32'd0);
            if (!e.trap) begin
              check("bus_addr", bus_addr, e.addr);
              check("bus_mask", 32'(bus_mask), 32'(e.mask));
              if (e.we) check("bus_wdata", bus_wdata, e.wdata);
            end
          end
          ren_cnt = 0; wen_cnt = 0; seen = 0; ready_due = 1;
        end
      end
    end
  end

  // Drive one access at posedge+1; ack after 'delay' BUSY cycles, optionally pulsing i_valid meanwhile.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [2:0] f3, input logic [4:0] rd, input int delay,
                       input logic [31:0] resp, input bit pulse);
    exp_t e;
    int   n;
    n = 0;
    while (!o_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_ready) check("ready_wait", 32'(o_ready), 32'd1);
    e = model(addr, wdata, we, f3, rd, resp);
    e.acc_cyc  = cyc;
    e.lat      = e.trap ? 1 : delay + 2;
    e.n_strobe = e.trap ? 0 : delay + 1;
    exp_q.push_back(e);
    i_valid = 1'b1; i_addr = addr; i_wdata = wdata; i_we = we; i_funct3 = f3; i_rd = rd;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    if (!e.trap) begin
      for (int k = 0; k < delay; k++) begin
        if (pulse) begin
          i_valid = 1'b1; i_rd = ~rd; i_addr = $urandom; i_we = ~we; i_wdata = $urandom;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
      end
      i_dmem_ack = 1'b1; i_dmem_rdata = resp;
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_addr = 0; i_wdata = 0; i_we = 0; i_funct3 = 0; i_rd = 0;
    i_dmem_ack = 1'b0; i_dmem_rdata = 0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_ren", 32'(o_dmem_ren), 32'd0);
    check("rst_wen", 32'(o_dmem_wen), 32'd0);
    check("rst_mis", 32'(o_misaligned), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_addr", o_dmem_addr, 32'd0);
    check("rst_wdata", o_dmem_wdata, 32'd0);
    check("rst_mask", 32'(o_dmem_mask), 32'd0);
    check("rst_rd", 32'(o_rd), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Directed cases.
    issue(32'h0000_0103, 32'h0000_00AB, 1'b1, 3'b000, 5'd3,  0, 32'h1111_1111, 1'b0); // SB
    issue(32'h0000_0201, 32'h0,         1'b0, 3'b000, 5'd4,  0, 32'h0000_8000, 1'b0); // LB
    issue(32'h0000_0201, 32'h0,         1'b0, 3'b100, 5'd5,  0, 32'h0000_8000, 1'b0); // LBU
    issue(32'h0000_0202, 32'h0,         1'b0, 3'b101, 5'd6,  0, 32'hBEEF_0000, 1'b0); // LHU
    issue(32'h0000_0040, 32'h0,         1'b0, 3'b010, 5'd17, 3, 32'hCAFE_F00D, 1'b1); // LW, slow ack
    issue(32'h0000_0042, 32'h0,         1'b0, 3'b010, 5'd8,  0, 32'h8765_4321, 1'b0); // LW misaligned
    issue(32'h0000_0106, 32'h1234_CAFE, 1'b1, 3'b001, 5'd9,  1, 32'h0,         1'b0); // SH upper
    issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 3'b010, 5'd10, 0, 32'h0,         1'b0); // SW
    issue(32'h0000_0200, 32'h0,         1'b0, 3'b001, 5'd11, 0, 32'h0000_8001, 1'b0); // LH
    issue(32'h0000_0044, 32'h0,         1'b0, 3'b011, 5'd12, 2, 32'h1234_5678, 1'b0); // funct3=011 as word
    issue(32'h0000_0001, 32'h0000_005A, 1'b1, 3'b100, 5'd13, 0, 32'h0,         1'b0); // store, funct3[2] ignored
    issue(32'h0000_0103, 32'h0000_BEEF, 1'b1, 3'b001, 5'd14, 0, 32'h0,         1'b0); // SH misaligned

    // Spurious ack while idle.
    i_dmem_ack = 1'b1;
    @(posedge i_clk); #1;
    check("idle_ack_ready", 32'(o_ready), 32'd1);
    check("idle_ack_done", 32'(o_done), 32'd0);
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    check("idle_ack_ren", 32'(o_dmem_ren), 32'd0);
    check("idle_ack_done2", 32'(o_done), 32'd0);

    // Reset while BUSY, ack arrives the cycle after.
    i_valid = 1'b1; i_addr = 32'h80; i_we = 1'b0; i_funct3 = 3'b010; i_rd = 5'd21;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check("pre_rst_ren", 32'(o_dmem_ren), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
    check("busy_rst_ren", 32'(o_dmem_ren), 32'd0);
    check("busy_rst_wen", 32'(o_dmem_wen), 32'd0);
    check("busy_rst_done", 32'(o_done), 32'd0);
    check("busy_rst_ready", 32'(o_ready), 32'd1);
    check("busy_rst_addr", o_dmem_addr, 32'd0);
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    check("late_ack_done", 32'(o_done), 32'd0);
    check("late_ack_ready", 32'(o_ready), 32'd1);

    // Reset beats a simultaneous accept.
    i_valid = 1'b1; i_rst = 1'b1; i_addr = 32'h90; i_we = 1'b1; i_funct3 = 3'b010;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_rst = 1'b0;
    check("rst_vs_accept_ready", 32'(o_ready), 32'd1);
    check("rst_vs_accept_wen", 32'(o_dmem_wen), 32'd0);
    @(posedge i_clk); #1;

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      issue({22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))}, $urandom,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port i_valid, input, 1, execute stage presents an access.
REQ-004 SHALL have port o_ready, output, 1, unit can accept; high only in IDLE.
REQ-005 SHALL have port i_addr, input, 32, byte address (ALU add result).
REQ-006 SHALL have port i_wdata, input, 32, store data (rs2).
REQ-007 SHALL have port i_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port i_funct3, input, 3, size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port i_rd, input, 5, destination register tag, returned with the result.
REQ-010 SHALL have ports o_dmem_addr (output, 32, word address, bits[1:0]=0), o_dmem_ren (output, 1), o_dmem_wen (output, 1), o_dmem_wdata (output, 32), o_dmem_mask (output, 4, byte enables).
REQ-011 SHALL have ports i_dmem_ack (input, 1, access complete) and i_dmem_rdata (input, 32, valid with ack).
REQ-012 SHALL have ports o_done (output, 1, one-cycle completion pulse), o_rdata (output, 32, load result, 0 for stores), o_rd (output, 5), o_misaligned (output, 1).

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; accept = i_valid & o_ready in IDLE -> BUSY; all request fields registered at accept.
REQ-014 SHALL drive o_dmem_ren/o_dmem_wen only in BUSY, held steady until i_dmem_ack; BUSY & ack -> DONE.
REQ-015 SHALL assert o_done for exactly the DONE cycle, then return to IDLE; o_rdata, o_rd, o_misaligned registered, valid while o_done=1.
REQ-016 SHALL give minimum latency: accept cycle N, strobe cycle N+1, ack at N+1 -> o_done at N+2, o_ready again at N+3.
REQ-017 SHALL ignore i_dmem_ack outside BUSY; i_valid ignored outside IDLE.
REQ-018 SHALL form store lanes: SB mask = 1<<addr[1:0], data byte replicated x4; SH mask 0011 (addr[1]=0) or 1100, half replicated x2; SW mask 1111.
REQ-019 SHALL form loads: select lane by addr[1:0]; funct3[2]=0 sign-extends, 1 zero-extends; word passes through; o_dmem_mask reflects the size for loads too.
REQ-020 SHALL treat funct3[1:0]=11 as word; ignore funct3[2] for stores.
REQ-021 SHALL define misaligned as: half with addr[0]=1, or word with addr[1:0]!=0; byte never misaligned.

Reset
REQ-022 SHALL, with i_rst high at an edge, enter IDLE; o_done, o_dmem_ren, o_dmem_wen, o_misaligned = 0; o_rdata, o_dmem_wdata, o_dmem_addr = 0; o_dmem_mask = 0; o_rd = 0.
REQ-023 SHALL abandon an in-flight access on reset in BUSY; no o_done produced; a later ack ignored.
REQ-024 SHALL give reset priority over accept and ack in the same cycle.

Configuration
REQ-025 SHALL use macro MISALIGN_TRAP_EN: defined -> misaligned access accepted, goes IDLE -> DONE without bus strobes, o_done=1, o_misaligned=1, o_rdata=0.
REQ-026 SHALL, without MISALIGN_TRAP_EN, tie o_misaligned to 0 and perform the access with offending address bits cleared (word -> lane 0, half -> lane addr[1]*2).

Verification
REQ-027 SHALL cover: SB addr 0x103, wdata 0x000000AB, ack on first BUSY cycle -> o_dmem_addr 0x100, mask 1000, wdata 0xABABABAB, o_done 2 cycles after accept.
REQ-028 SHALL cover: LB addr 0x201, rdata 0x0000_8000 -> o_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202, rdata 0xBEEF0000 -> 0x0000BEEF.
REQ-029 SHALL cover: LW addr 0x40 with ack delayed 3 cycles -> strobe held 4 cycles, o_ready low throughout, i_valid pulses ignored, o_rd equals captured tag.
REQ-030 SHALL cover: LW addr 0x42 -> with MISALIGN_TRAP_EN o_misaligned=1, no strobe, o_rdata 0; without it, read of 0x40, o_misaligned 0.
REQ-031 SHALL cover: i_rst asserted in BUSY, ack next cycle -> strobes low, no o_done, o_ready high after reset.
REQ-032 SHALL cover: spurious i_dmem_ack in IDLE -> no state change, no o_done.
